// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry valid/ready skid FIFO with N/Z/C/V flag derivation and
// an architectural flag register. Optional sticky overflow enabled by ALU_STICKY_OVERFLOW_EN.
module alu_result_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] result_in,
  input  logic [2:0]  sel_in,
  input  logic        carry_out_in,
  input  logic        carry_msb_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_result,
  output logic [3:0]  out_flags,
  output logic        out_illegal,
  output logic [3:0]  flags_q,
  output logic        sv_q,
  input  logic        sv_clr
);

  localparam logic [2:0] SelAnd = 3'b000;
  localparam logic [2:0] SelOr  = 3'b001;
  localparam logic [2:0] SelAdd = 3'b010;
  localparam logic [2:0] SelXor = 3'b101;

  logic [23:0] data_q [2];
  logic [3:0]  flg_q  [2];
  logic [1:0]  ill_q;
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;

  logic        push, pop;
  logic [3:0]  new_flags;
  logic        new_ill;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_flags = 4'b0000;
    new_ill   = 1'b0;
    unique case (sel_in)
      SelAnd, SelOr, SelXor: new_flags = {result_in[23], result_in == 24'h000000, 2'b00};
      SelAdd: new_flags = {result_in[23], result_in == 24'h000000, carry_out_in,
                           carry_out_in ^ carry_msb_in};
      default: new_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        flg_q[i]  <= '0;
      end
      ill_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      flags_q  <= 4'b0000;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= result_in;
        flg_q[wr_ptr_q]  <= new_flags;
        ill_q[wr_ptr_q]  <= new_ill;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        flags_q  <= flg_q[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  // Stale storage after a pop must not leak out while empty.
  assign out_result  = out_valid ? data_q[rd_ptr_q] : 24'h000000;
  assign out_flags   = out_valid ? flg_q[rd_ptr_q] : 4'b0000;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;

`ifdef ALU_STICKY_OVERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_q <= 1'b0;
    end else if (sv_clr) begin
      sv_q <= 1'b0;
    end else if (pop && flg_q[rd_ptr_q][0]) begin
      sv_q <= 1'b1;
    end
  end
`else
  logic sv_clr_unused;
  assign sv_clr_unused = sv_clr;
  assign sv_q = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes model predictions on accept,
// a negedge monitor compares the head entry and architectural flags.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] result_in = '0;
  logic [2:0]  sel_in = '0;
  logic        carry_out_in = 1'b0, carry_msb_in = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, sv_clr = 1'b0;
  logic        in_ready, out_valid, out_illegal, sv_q;
  logic [23:0] out_result;
  logic [3:0]  out_flags, flags_q;

  alu_result_stage dut (
    .clk(clk), .reset(reset), .result_in(result_in), .sel_in(sel_in),
    .carry_out_in(carry_out_in), .carry_msb_in(carry_msb_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_illegal(out_illegal),
    .flags_q(flags_q), .sv_q(sv_q), .sv_clr(sv_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] r;
    logic [3:0]  f;
    logic        ill;
  } beat_t;

  beat_t      q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_arch = 4'b0000;
  logic       exp_sv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: flags from the operation's meaning (sign, zero, carry, signed overflow).
  function automatic beat_t model(input logic [23:0] r, input logic [2:0] s,
                                  input logic co, input logic cm);
    beat_t b;
    logic  neg, zero;
    neg   = $signed(r) < 0;
    zero  = (r == 0);
    b.r   = r;
    b.f   = 4'b0000;
    b.ill = 1'b0;
    case (s)
      3'b000, 3'b001, 3'b101: b.f = {neg, zero, 1'b0, 1'b0};
      3'b010:                 b.f = {neg, zero, co, co != cm};
      default:                b.ill = 1'b1;
    endcase
    return b;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_arch = 4'b0000;
      exp_sv   = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      chk("rst_flags_q", 32'(flags_q), 32'd0);
      chk("rst_sv_q", 32'(sv_q), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("flags_q", 32'(flags_q), 32'(exp_arch));
      chk("sv_q", 32'(sv_q), 32'(exp_sv));
      if (q.size() == 0) begin
        chk("empty_result", 32'(out_result), 32'd0);
        chk("empty_flags", 32'(out_flags), 32'd0);
      end else begin
        chk("out_result", 32'(out_result), 32'(q[0].r));
        chk("out_flags", 32'(out_flags), 32'(q[0].f));
        chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
`ifdef ALU_STICKY_OVERFLOW_EN
      if (sv_clr) exp_sv = 1'b0;
      else if (q.size() != 0 && out_ready && q[0].f[0]) exp_sv = 1'b1;
`endif
      if (q.size() != 0 && out_ready) begin
        exp_arch = q[0].f;
        void'(q.pop_front());
      end
    end
  end

  task automatic cycle(input logic v, input logic [23:0] r, input logic [2:0] s,
                       input logic co, input logic cm, input logic ordy, input logic clr,
                       output logic acc);
    in_valid = v; result_in = r; sel_in = s; carry_out_in = co; carry_msb_in = cm;
    out_ready = ordy; sv_clr = clr;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) q.push_back(model(r, s, co, cm));
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, 24'h0, 3'b000, 1'b0, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
    chk("drain_bound", 32'(q.size()), 32'd0);
    idle(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic acc;
    logic [23:0] r;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1'b0);

    // Reset with two entries buffered.
    cycle(1'b1, 24'h000111, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 24'h000222, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    idle(1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    do_reset();
    idle(1'b0);

    // ADD zero with carry, no overflow.
    cycle(1'b1, 24'h000000, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("add_zero_flags_q", 32'(flags_q), 32'h6);

    // ADD negative with overflow, then sticky clear.
    cycle(1'b1, 24'h800000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("ovf_flags_q", 32'(flags_q), 32'h9);
`ifdef ALU_STICKY_OVERFLOW_EN
    chk("sv_set", 32'(sv_q), 32'd1);
`else
    chk("sv_tied", 32'(sv_q), 32'd0);
`endif
    cycle(1'b0, 24'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    chk("sv_clr", 32'(sv_q), 32'd0);

    // Backpressure: two beats fill the buffer, third refused.
    cycle(1'b1, 24'h00000F, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    cycle(1'b1, 24'hFFFFFF, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_acc2", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 24'h0ABCDE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_third_refused", 32'(acc), 32'd0);
    end
    drain();
    chk("bp_flags_q", 32'(flags_q), 32'h8);

    // Illegal select.
    cycle(1'b1, 24'h123456, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    idle(1'b0);
    chk("ill_result", 32'(out_result), 32'h123456);
    chk("ill_flags", 32'(out_flags), 32'h0);
    chk("ill_bit", 32'(out_illegal), 32'd1);
    drain();
    chk("ill_flags_q", 32'(flags_q), 32'h0);

    // Count 1 with simultaneous accept and pop for 10 beats.
    cycle(1'b1, 24'h000001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 24'(i * 24'h010203), 3'b010, i[0], i[1], 1'b1, 1'b0, acc);
      chk("b2b_acc", 32'(acc), 32'd1);
    end
    drain();

    // Randomized traffic with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: r = 24'h000000;
        1: r = 24'h800000 | 24'($urandom_range(255));
        default: r = 24'($urandom);
      endcase
      if (i == 200) do_reset();
      cycle($urandom_range(3) != 0, r, 3'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(2) != 0, $urandom_range(15) == 0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the per-bit ALU function muxes in the 24-bit single-cycle CPU. It captures the 24-bit ALU result together with the operation select that produced it, and derives the N/Z/C/V flags. It buffers up to two results in a valid/ready skid buffer toward writeback. It also maintains the architectural flag register, which updates only when a result is consumed.

## Interface
- Parameters: none. Data width is fixed at 24 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `result_in` in 24: ALU result assembled from the 24 bit-slice mux outputs.
- `sel_in` in 3: operation select driven to the slices. Legal encodings:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 101 XOR
- `carry_out_in` in 1: carry out of bit 23 (ADD only).
- `carry_msb_in` in 1: carry into bit 23 (ADD only).
- `in_valid` in 1: input beat present.
- `in_ready` out 1: stage can accept a beat.
- `out_valid` out 1: buffered beat available to writeback.
- `out_ready` in 1: writeback accepts the beat.
- `out_result` out 24: head-entry result.
- `out_flags` out 4: head-entry flags {N,Z,C,V}.
- `out_illegal` out 1: head entry was produced by a non-legal `sel_in`.
- `flags_q` out 4: architectural {N,Z,C,V}, updated on output handshake.
- `sv_q` out 1: sticky overflow. Meaningful only with the macro; see Configuration.
- `sv_clr` in 1: clears `sv_q`.

## Operation
- Input accept occurs when `in_valid && in_ready`.
- Output pop occurs when `out_valid && out_ready`.
- Buffer: 2-entry in-order FIFO with occupancy count 0..2.
  - Wrap-around pointers, 1 bit each.
  - `in_ready = (count != 2)`, decoded from registered state only; no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
- Flag derivation, computed at accept and stored with the entry:
  - N = `result_in[23]`.
  - Z = (`result_in` == 24'h000000).
  - ADD: C = `carry_out_in`; V = `carry_out_in ^ carry_msb_in`.
  - AND/OR/XOR: C = 0, V = 0.
  - Illegal sel (011, 100, 110, 111): result stored unchanged, flags forced to 4'b0000, illegal bit = 1.
- `flags_q` loads the head entry's `out_flags` on every pop.
  - An illegal entry still loads its flags, which are 0000.
  - `flags_q` holds when there is no pop.
- Simultaneous accept and pop:
  - count 1: count stays 1; the new entry becomes head next cycle.
  - count 0: no pop is possible, so this is a plain accept.
  - count 2: accept is blocked by `in_ready` = 0; the pop proceeds and `in_ready` rises the next cycle.
- Reset, including mid-transfer: buffer emptied and count = 0; all in-flight entries are discarded.
- Reset values of every output:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_result` = 0
  - `out_flags` = 0
  - `out_illegal` = 0
  - `flags_q` = 0
  - `sv_q` = 0
- `out_result`, `out_flags` and `out_illegal` are driven from the head-entry storage. They read 0 when empty.

## Timing
- Latency: a beat accepted on edge k is visible on the outputs with `out_valid` = 1 after edge k.
- With `out_ready` held 1: sustained throughput of 1 beat per cycle, with 1-cycle latency.
- Data and flags of the head entry are stable while `out_valid && !out_ready`.
- `flags_q` changes on the edge that completes the pop.
- `sv_q` updates on the same edge as `flags_q`.

## Configuration
- Macro `ALU_STICKY_OVERFLOW_EN`.
- Defined:
  - `sv_q` sets on any pop whose V = 1.
  - `sv_q` clears when `sv_clr` = 1.
  - Clear has priority over a same-cycle set.
- Undefined:
  - `sv_q` tied to 0 and `sv_clr` ignored.
  - Port list is identical in both builds.

## Test plan
- Reset mid-stream (count 2, then `reset` pulse): `in_ready` = 1, `out_valid` = 0, `flags_q` = 0000 after reset.
- ADD, result 24'h000000, `carry_out_in` = 1, `carry_msb_in` = 1, `out_ready` = 1: `out_flags` = {0,1,1,0}; `flags_q` = 0110 one edge after the pop.
- ADD, result 24'h800000, `carry_out_in` = 0, `carry_msb_in` = 1: `out_flags` = {1,0,0,1}.
  - With the macro, `sv_q` = 1 after the pop.
  - Then `sv_clr` = 1 → `sv_q` = 0.
  - Without the macro, `sv_q` stays 0.
- Backpressure with `out_ready` = 0: accept XOR 24'h00000F, then OR 24'hFFFFFF.
  - `in_ready` = 0 after the second accept.
  - A third beat is not taken.
  - Release `out_ready`: beats emerge in order 00000F then FFFFFF; flags {0,0,0,0} then {1,0,0,0}.
- Illegal sel 3'b110 with result 24'h123456: `out_result` = 123456, `out_flags` = 0000, `out_illegal` = 1.
- Count 1, with accept and pop on the same cycle: count stays 1, no beat is lost or duplicated, and `in_ready` stays 1 across 10 back-to-back beats.
